multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle control FSM that drives the execute stage.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and generates every datapath select/enable. This includes ALU_Bin_Sel and ALU_func for the ALU stage, and it consumes the ALU stage's Zero flag.
- Handles a req/ack handshake to a shared instruction/data memory, so fetch and load/store phases tolerate wait states.

Parameters:
- OPW, 6, opcode field width (Instr[31:26]).
- FUNCW, 6, R-type func field width (Instr[5:0]).

Ports:
- Clk  in  1  single clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- Instr  in  32  current IR contents.
- Zero  in  1  ALU zero flag from execute stage.
- Mem_Ack  in  1  memory completion strobe.
- Mem_Req  out  1  memory request, held until Ack.
- Mem_WrEn  out  1  1 = write access (valid with Mem_Req).
- ByteOp  out  1  1 = byte access (lb/sb).
- IR_LdEn  out  1  load IR from memory data.
- PC_LdEn  out  1  load PC.
- PC_sel  out  1  0 = PC+4, 1 = PC+4+(SignExt(imm)<<2).
- RF_WrEn  out  1  register file write.
- RF_WrData_sel  out  1  0 = ALU_out, 1 = memory data.
- RF_B_sel  out  1  0 = rt (Instr[15:11]), 1 = rd (Instr[20:16]).
- ImmExt  out  2  00 zero-ext, 01 sign-ext, 10 <<16, 11 sign-ext<<2.
- ALU_Bin_Sel  out  1  0 = RF_B, 1 = Immed.
- ALU_func  out  4  ALU opcode.
- Illegal_Op  out  1  see Optional Feature; tied 0 when compiled out.

Behaviour:
- States: S_FETCH, S_DECODE, S_EXEC, S_MEMACC, S_WB, S_BRANCH (plus S_TRAP with feature). Outputs are Moore functions of state and opcode.
- Reset (async, Reset=0): state=S_FETCH. All outputs 0 while Reset is asserted, except ALU_func=0000 (add).
- Reset released mid-memory-access: the access is abandoned, and the first cycle after release drives Mem_Req=1 in S_FETCH.
- S_FETCH:
  - Mem_Req=1, Mem_WrEn=0.
  - On Mem_Ack=1 (ack in the same cycle as req is legal): IR_LdEn=1, PC_LdEn=1, PC_sel=0, next state S_DECODE.
  - Otherwise stay; IR_LdEn and PC_LdEn are 0.
- S_DECODE: 1 cycle, RF read. Next state:
  - S_BRANCH for b/beq/bne.
  - S_EXEC for all other legal ops.
- S_EXEC (1 cycle):
  - R-type (opcode 100000): ALU_Bin_Sel=0, ALU_func=Instr[3:0].
  - addi (110000) / li (111000): ALU_Bin_Sel=1, func 0000, ImmExt 01.
  - lui (111001): ALU_Bin_Sel=1, func 0000, ImmExt 10.
  - andi (110010): ALU_Bin_Sel=1, func 0010, ImmExt 00.
  - ori (110011): ALU_Bin_Sel=1, func 0011, ImmExt 00.
  - lb/lw/sb/sw (000011, 001111, 000111, 011111): ALU_Bin_Sel=1, func 0000, ImmExt 01, RF_B_sel=1 for stores.
  - Next state: S_MEMACC for loads/stores, else S_WB.
- S_MEMACC:
  - Mem_Req=1; Mem_WrEn=1 for stores; ByteOp=1 for lb/sb.
  - ALU_func and ALU_Bin_Sel stay at their EXEC values so the address remains stable.
  - On Mem_Ack: loads go to S_WB; stores go to S_FETCH.
- S_WB: RF_WrEn=1 for exactly 1 cycle. RF_WrData_sel=1 for loads, else 0. Next state S_FETCH.
- S_BRANCH:
  - RF_B_sel=1, ALU_Bin_Sel=0, func 0001 (sub), ImmExt 11.
  - Taken if b, (beq AND Zero=1), or (bne AND Zero=0). Taken → PC_LdEn=1, PC_sel=1.
  - Next state S_FETCH.
- Mem_Ack outside S_FETCH/S_MEMACC is ignored.
- Latency with zero-wait memory (ack same cycle):
  - R/I-ALU: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Branch: 3 cycles.
  - Each memory wait cycle adds 1.
- Unknown opcode (feature off): treated as NOP, DECODE → S_FETCH, no writes.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined: unknown opcode, or R-type func not in the ALU's legal set, goes DECODE → S_TRAP.
  - S_TRAP holds Illegal_Op=1 with every other enable 0 until Reset.
- Undefined: NOP behaviour as above; Illegal_Op tied 0.

Decomposition:
- Package multicycle_pkg: state enum, opcode localparams (OP_RTYPE, OP_ADDI, OP_LI, OP_LUI, OP_ANDI, OP_ORI, OP_B, OP_BEQ, OP_BNE, OP_LB, OP_LW, OP_SB, OP_SW), ALU_func constants, ImmExt codes.
- One natural sub-module: ctrl_op_decode. It is combinational: opcode/func → class (alu_r, alu_i, load, store, branch, illegal), ALU_func and ImmExt.
- The FSM stays in multicycle_ctrl.

Test Plan:
- R-type add (op 100000, func 110000), Mem_Ack tied 1 → IR_LdEn at cycle 1; ALU_Bin_Sel=0, ALU_func=0000 at cycle 3; RF_WrEn=1 only at cycle 4; back to Mem_Req=1 at cycle 5.
- lw (op 001111), Mem_Ack delayed 3 cycles in MEMACC → Mem_Req stays 1 with Mem_WrEn=0 for 4 cycles; then RF_WrEn=1 with RF_WrData_sel=1 for 1 cycle.
- beq with Zero=1 → S_BRANCH drives PC_LdEn=1, PC_sel=1, ALU_func=0001. With Zero=0 → PC_LdEn=0. bne gives the inverse; b is always taken.
- sw (op 011111) → RF_B_sel=1, ALU_Bin_Sel=1, ImmExt=01; Mem_WrEn=1 until ack; RF_WrEn never asserted.
- Reset driven low during S_MEMACC with Mem_Req=1 → all outputs 0 immediately (async). After release, Mem_Req=1 (fetch) next cycle and no RF_WrEn.
- Opcode 101010: with the macro, Illegal_Op=1 held and no further Mem_Req. Without it, DECODE → FETCH with no write.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle controller. The optional trap state
// exists only when MULTICYCLE_CTRL_ILLEGAL_TRAP_EN is defined.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMACC,
        S_WB,
        S_BRANCH
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    localparam logic [1:0] IMM_ZEXT     = 2'b00;
    localparam logic [1:0] IMM_SEXT     = 2'b01;
    localparam logic [1:0] IMM_HI16     = 2'b10;
    localparam logic [1:0] IMM_SEXT_SH2 = 2'b11;

    typedef enum logic [2:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } op_class_t;

    typedef enum logic [1:0] {
        BR_ALWAYS,
        BR_EQ,
        BR_NE
    } br_kind_t;

    typedef struct packed {
        op_class_t  op_class;
        br_kind_t   br_kind;
        logic       is_byte;
        logic [3:0] alu_func;
        logic [1:0] imm_ext;
    } dec_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_wr_en;
        logic       byte_op;
        logic       ir_ld_en;
        logic       pc_ld_en;
        logic       pc_sel;
        logic       rf_wr_en;
        logic       rf_wr_data_sel;
        logic       rf_b_sel;
        logic [1:0] imm_ext;
        logic       alu_bin_sel;
        logic [3:0] alu_func;
        logic       illegal_op;
    } ctrl_out_t;

    // R-type funcs the ALU implements: upper bits 11, low nibble one of the ALU ops.
    function automatic logic alu_func_legal(input logic [5:0] func);
        return (func[5:4] == 2'b11) &&
               (func[3:0] inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                  4'h8, 4'h9, 4'hA, 4'hC, 4'hD});
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the datapath
// plus memory side (slave).
interface multicycle_ctrl_if;
    logic [31:0] Instr;
    logic        Zero;
    logic        Mem_Ack;
    logic        Mem_Req;
    logic        Mem_WrEn;
    logic        ByteOp;
    logic        IR_LdEn;
    logic        PC_LdEn;
    logic        PC_sel;
    logic        RF_WrEn;
    logic        RF_WrData_sel;
    logic        RF_B_sel;
    logic [1:0]  ImmExt;
    logic        ALU_Bin_Sel;
    logic [3:0]  ALU_func;
    logic        Illegal_Op;

    modport master (
        input  Instr, Zero, Mem_Ack,
        output Mem_Req, Mem_WrEn, ByteOp, IR_LdEn, PC_LdEn, PC_sel, RF_WrEn,
               RF_WrData_sel, RF_B_sel, ImmExt, ALU_Bin_Sel, ALU_func, Illegal_Op
    );

    modport slave (
        output Instr, Zero, Mem_Ack,
        input  Mem_Req, Mem_WrEn, ByteOp, IR_LdEn, PC_LdEn, PC_sel, RF_WrEn,
               RF_WrData_sel, RF_B_sel, ImmExt, ALU_Bin_Sel, ALU_func, Illegal_Op
    );
endinterface

// File: rtl/ctrl_op_decode.sv
// Combinational opcode/func classifier: instruction class, branch kind, byte access,
// ALU function and immediate-extension mode.
module ctrl_op_decode
    import multicycle_pkg::*;
#(
    parameter int OPW           = 6,
    parameter int FUNCW         = 6,
    parameter bit TRAP_BAD_FUNC = 1'b0
) (
    input  logic [OPW-1:0]   opcode,
    input  logic [FUNCW-1:0] func,
    output dec_t             dec
);

    always_comb begin
        dec.op_class = CLS_ILLEGAL;
        dec.br_kind  = BR_ALWAYS;
        dec.is_byte  = 1'b0;
        dec.alu_func = ALU_ADD;
        dec.imm_ext  = IMM_ZEXT;
        case (opcode)
            OP_RTYPE: begin
                // Bad funcs only become illegal when the trap is built in.
                dec.op_class = (TRAP_BAD_FUNC && !alu_func_legal(func)) ? CLS_ILLEGAL : CLS_ALU_R;
                dec.alu_func = func[3:0];
            end
            OP_ADDI, OP_LI: begin
                dec.op_class = CLS_ALU_I;
                dec.imm_ext  = IMM_SEXT;
            end
            OP_LUI: begin
                dec.op_class = CLS_ALU_I;
                dec.imm_ext  = IMM_HI16;
            end
            OP_ANDI: begin
                dec.op_class = CLS_ALU_I;
                dec.alu_func = ALU_AND;
            end
            OP_ORI: begin
                dec.op_class = CLS_ALU_I;
                dec.alu_func = ALU_OR;
            end
            OP_LB, OP_LW: begin
                dec.op_class = CLS_LOAD;
                dec.is_byte  = (opcode == OP_LB);
                dec.imm_ext  = IMM_SEXT;
            end
            OP_SB, OP_SW: begin
                dec.op_class = CLS_STORE;
                dec.is_byte  = (opcode == OP_SB);
                dec.imm_ext  = IMM_SEXT;
            end
            OP_B, OP_BEQ, OP_BNE: begin
                dec.op_class = CLS_BRANCH;
                dec.br_kind  = (opcode == OP_BEQ) ? BR_EQ :
                               (opcode == OP_BNE) ? BR_NE : BR_ALWAYS;
                dec.alu_func = ALU_SUB;
                dec.imm_ext  = IMM_SEXT_SH2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback with a req/ack memory
// handshake. Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap on illegal instructions.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int FUNCW = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    multicycle_ctrl_if.master bus
);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t    state_reg, state_next;
    dec_t      dec;
    ctrl_out_t ctrl, ctrl_gated;
    logic      is_load, is_store, br_taken, exec_hold;
    logic      unused_instr_bits;

    assign unused_instr_bits = ^bus.Instr[31-OPW:FUNCW];

    ctrl_op_decode #(
        .OPW           (OPW),
        .FUNCW         (FUNCW),
        .TRAP_BAD_FUNC (TRAP_EN)
    ) u_decode (
        .opcode (bus.Instr[31:32-OPW]),
        .func   (bus.Instr[FUNCW-1:0]),
        .dec    (dec)
    );

    assign is_load  = (dec.op_class == CLS_LOAD);
    assign is_store = (dec.op_class == CLS_STORE);

    always_comb begin
        case (dec.br_kind)
            BR_EQ:   br_taken = bus.Zero;
            BR_NE:   br_taken = !bus.Zero;
            default: br_taken = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_reg <= S_FETCH;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        ctrl       = '0;
        exec_hold  = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (bus.Mem_Ack) begin
                    ctrl.ir_ld_en = 1'b1;
                    ctrl.pc_ld_en = 1'b1;
                    state_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                case (dec.op_class)
                    CLS_BRANCH:  state_next = S_BRANCH;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    CLS_ILLEGAL: state_next = S_TRAP;
`else
                    CLS_ILLEGAL: state_next = S_FETCH;
`endif
                    default:     state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                exec_hold  = 1'b1;
                state_next = (is_load || is_store) ? S_MEMACC : S_WB;
            end
            S_MEMACC: begin
                exec_hold      = 1'b1;
                ctrl.mem_req   = 1'b1;
                ctrl.mem_wr_en = is_store;
                ctrl.byte_op   = dec.is_byte;
                if (bus.Mem_Ack) state_next = is_load ? S_WB : S_FETCH;
            end
            S_WB: begin
                // ALU selects stay put so a combinational ALU_out is still valid here.
                exec_hold           = 1'b1;
                ctrl.rf_wr_en       = 1'b1;
                ctrl.rf_wr_data_sel = is_load;
                state_next          = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.rf_b_sel = 1'b1;
                ctrl.alu_func = ALU_SUB;
                ctrl.imm_ext  = IMM_SEXT_SH2;
                ctrl.pc_ld_en = br_taken;
                ctrl.pc_sel   = br_taken;
                state_next    = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: ctrl.illegal_op = 1'b1;
`endif
            default: state_next = S_FETCH;
        endcase
        if (exec_hold) begin
            ctrl.alu_bin_sel = (dec.op_class != CLS_ALU_R);
            ctrl.alu_func    = dec.alu_func;
            ctrl.imm_ext     = dec.imm_ext;
            ctrl.rf_b_sel    = is_store;
        end
    end

    // Outputs are forced quiet for as long as reset is held, not just at the edge.
    assign ctrl_gated = Reset ? ctrl : '0;

    assign bus.Mem_Req       = ctrl_gated.mem_req;
    assign bus.Mem_WrEn      = ctrl_gated.mem_wr_en;
    assign bus.ByteOp        = ctrl_gated.byte_op;
    assign bus.IR_LdEn       = ctrl_gated.ir_ld_en;
    assign bus.PC_LdEn       = ctrl_gated.pc_ld_en;
    assign bus.PC_sel        = ctrl_gated.pc_sel;
    assign bus.RF_WrEn       = ctrl_gated.rf_wr_en;
    assign bus.RF_WrData_sel = ctrl_gated.rf_wr_data_sel;
    assign bus.RF_B_sel      = ctrl_gated.rf_b_sel;
    assign bus.ImmExt        = ctrl_gated.imm_ext;
    assign bus.ALU_Bin_Sel   = ctrl_gated.alu_bin_sel;
    assign bus.ALU_func      = ctrl_gated.alu_func;
    assign bus.Illegal_Op    = ctrl_gated.illegal_op;

endmodule
